// File: rtl/jtpopeye_ps2_keyrx.sv
// jtpopeye_ps2_keyrx: raw PS/2 keyboard receiver.
// Turns PS/2 clock/data pins into the 11-bit key event word
// {toggle, pressed, extended, code[7:0]} used by the keyboard latch logic.
// Optional build macro JTPOPEYE_PS2_ERRCNT_EN adds err_cnt, a saturating
// count of frame_err pulses.
module jtpopeye_ps2_keyrx #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 40000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_valid,
    output logic        frame_err
`ifdef JTPOPEYE_PS2_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER - 1);
    localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT - 1);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_PAUSE = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Synchroniser stages
    logic clk_s1_q, clk_s2_q;
    logic dat_s1_q, dat_s2_q;

    // Clock filter
    logic [FW-1:0] flt_cnt_q;
    logic          flt_lvl_q;
    logic          fall_d;

    // Frame receiver
    state_t        state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [WW-1:0] wd_q;
    logic          ext_q;
    logic          brk_q;
    logic [2:0]    skip_q;
    logic          frame_good_d;

    // Two-stage synchronisers for both PS/2 lines (idle level is high)
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Debounce the PS/2 clock: level flips only after FILTER differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_cnt_q <= '0;
            flt_lvl_q <= 1'b1;
        end else if (clk_s2_q != flt_lvl_q) begin
            if (flt_cnt_q == FLT_MAX) begin
                flt_cnt_q <= '0;
                flt_lvl_q <= clk_s2_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + FW'(1);
            end
        end else begin
            flt_cnt_q <= '0;
        end
    end

    // Fall strobe is the cycle in which the filtered level is about to go 1->0;
    // the stop frame check uses the data sampled in that same cycle
    always_comb begin
        fall_d       = flt_lvl_q & ~clk_s2_q & (flt_cnt_q == FLT_MAX);
        frame_good_d = dat_s2_q & (^{shift_q, par_q});
    end

    // Frame FSM with watchdog, prefix tracking and registered event outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            wd_q      <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            skip_q    <= '0;
            ps2_key   <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;

            if (state_q == S_IDLE) begin
                wd_q <= '0;
            end else if (fall_d) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + WW'(1);
            end

            if (state_q != S_IDLE && !fall_d && wd_q == WD_MAX) begin
                state_q   <= S_IDLE;
                frame_err <= 1'b1;
                ext_q     <= 1'b0;
                brk_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (fall_d && !dat_s2_q) begin
                            state_q  <= S_DATA;
                            bitcnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        if (fall_d) begin
                            shift_q  <= {dat_s2_q, shift_q[7:1]};
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                state_q <= S_PARITY;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (fall_d) begin
                            par_q   <= dat_s2_q;
                            state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (fall_d) begin
                            state_q <= S_IDLE;
                            if (!frame_good_d) begin
                                frame_err <= 1'b1;
                                ext_q     <= 1'b0;
                                brk_q     <= 1'b0;
                                skip_q    <= '0;
                            end else if (skip_q != '0) begin
                                skip_q <= skip_q - 3'd1;
                            end else begin
                                case (shift_q)
                                    CODE_EXT:   ext_q  <= 1'b1;
                                    CODE_BRK:   brk_q  <= 1'b1;
                                    CODE_PAUSE: skip_q <= PAUSE_SKIP;
                                    default: begin
                                        ps2_key   <= {~ps2_key[10], ~brk_q, ext_q, shift_q};
                                        key_valid <= 1'b1;
                                        ext_q     <= 1'b0;
                                        brk_q     <= 1'b0;
                                    end
                                endcase
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef JTPOPEYE_PS2_ERRCNT_EN
    // Saturating count of frame errors
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (frame_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    // No error counter in this build
`endif

endmodule
